tetris_piece_row_logic: RTL and testbench

Shared helper block for the Tetris top level. It bundles three functions:
- combinational geometry for the falling tetromino (cell indices and bounding box);
- a sequential full-row scanner over the placed-cell bitmap;
- a bank of input debouncers that emit one-cycle press and release pulses.

It runs on the 25 MHz game clock and feeds the move, rotate, clear and game-mode logic.

---
 rtl/tetris_piece_row_logic.sv | 221 ++++++++++++++++++++++
 tb/tb_tetris_piece_row_logic.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/tetris_piece_row_logic.sv
// ---------------------------------------------------------------------------
// tetris_piece_row_logic
//
// Shared helper block for the Tetris top level:
//   * combinational geometry of the falling tetromino (cell indices, bbox);
//   * sequential full-row scanner over the placed-cell bitmap;
//   * a bank of input debouncers emitting one-cycle press/release pulses.
//
// Configuration macro:
//   DEBOUNCE_SYNC_EN  defined   -> two-flop synchronizer ahead of each debouncer
//                     undefined -> single sampling flop (latency one cycle less)
//
// Ports:
//   clk                game clock (25 MHz), all state on rising edge
//   rst                synchronous active-high reset
//   piece, pos_x,
//   pos_y, rot         falling piece type, bbox top-left, rotation
//   blk_1..blk_4       flattened cell indices (y*BLOCK_WIDTH + x)
//   width, height      bounding-box size of the piece in its rotation
//   pause              freezes the row scan
//   placed_tetrominos  placed-cell bitmap, bit index y*BLOCK_WIDTH + x
//   row, row_en        full row index and its one-cycle valid pulse
//   raw                asynchronous buttons/switches
//   db_enabled         per-bit one-cycle pulse on accepted 0->1
//   db_disabled        per-bit one-cycle pulse on accepted 1->0
// ---------------------------------------------------------------------------
module tetris_piece_row_logic #(
    parameter int BLOCK_WIDTH     = 10,
    parameter int BLOCK_HEIGHT    = 20,
    parameter int NUM_INPUTS      = 7,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [1:0]                        piece,
    input  logic [3:0]                        pos_x,
    input  logic [4:0]                        pos_y,
    input  logic [1:0]                        rot,
    output logic [7:0]                        blk_1,
    output logic [7:0]                        blk_2,
    output logic [7:0]                        blk_3,
    output logic [7:0]                        blk_4,
    output logic [2:0]                        width,
    output logic [2:0]                        height,
    input  logic                              pause,
    input  logic [BLOCK_WIDTH*BLOCK_HEIGHT-1:0] placed_tetrominos,
    output logic [4:0]                        row,
    output logic                              row_en,
    input  logic [NUM_INPUTS-1:0]             raw,
    output logic [NUM_INPUTS-1:0]             db_enabled,
    output logic [NUM_INPUTS-1:0]             db_disabled
);

    typedef enum logic [1:0] {
        PIECE_EMPTY = 2'd0,
        PIECE_I     = 2'd1,
        PIECE_O     = 2'd2,
        PIECE_T     = 2'd3
    } piece_e;

    localparam logic [7:0] W8    = 8'(BLOCK_WIDTH);
    localparam int         CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    // -----------------------------------------------------------------------
    // Geometry: per-cell (dx,dy) offsets, then 8-bit flattened indices.
    // -----------------------------------------------------------------------
    logic [1:0] dx [4];
    logic [1:0] dy [4];
    logic [7:0] idx [4];
    logic       piece_valid;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // through the case leaves a value unassigned and infers a latch.
        dx          = '{default: 2'd0};
        dy          = '{default: 2'd0};
        width       = 3'd0;
        height      = 3'd0;
        piece_valid = 1'b1;
        case (piece_e'(piece))
            PIECE_I: begin
                if (rot[0]) begin
                    dy     = '{2'd0, 2'd1, 2'd2, 2'd3};
                    width  = 3'd1;
                    height = 3'd4;
                end else begin
                    dx     = '{2'd0, 2'd1, 2'd2, 2'd3};
                    width  = 3'd4;
                    height = 3'd1;
                end
            end
            PIECE_O: begin
                dx     = '{2'd0, 2'd1, 2'd0, 2'd1};
                dy     = '{2'd0, 2'd0, 2'd1, 2'd1};
                width  = 3'd2;
                height = 3'd2;
            end
            PIECE_T: begin
                case (rot)
                    2'd0: begin
                        dx = '{2'd0, 2'd1, 2'd2, 2'd1};
                        dy = '{2'd0, 2'd0, 2'd0, 2'd1};
                        width = 3'd3; height = 3'd2;
                    end
                    2'd1: begin
                        dx = '{2'd1, 2'd0, 2'd1, 2'd1};
                        dy = '{2'd0, 2'd1, 2'd1, 2'd2};
                        width = 3'd2; height = 3'd3;
                    end
                    2'd2: begin
                        dx = '{2'd1, 2'd0, 2'd1, 2'd2};
                        dy = '{2'd0, 2'd1, 2'd1, 2'd1};
                        width = 3'd3; height = 3'd2;
                    end
                    default: begin
                        dx = '{2'd0, 2'd0, 2'd1, 2'd0};
                        dy = '{2'd0, 2'd1, 2'd1, 2'd2};
                        width = 3'd2; height = 3'd3;
                    end
                endcase
            end
            default: piece_valid = 1'b0;
        endcase

        // Unclamped 8-bit arithmetic; the caller keeps the piece on the board.
        for (int i = 0; i < 4; i++) begin
            idx[i] = piece_valid
                   ? (8'(pos_y) + 8'(dy[i])) * W8 + 8'(pos_x) + 8'(dx[i])
                   : 8'd0;
        end
    end

    assign blk_1 = idx[0];
    assign blk_2 = idx[1];
    assign blk_3 = idx[2];
    assign blk_4 = idx[3];

    // -----------------------------------------------------------------------
    // Row scanner: one row tested per cycle, registered result.
    // -----------------------------------------------------------------------
    logic [4:0]             scan;
    logic [BLOCK_WIDTH-1:0] scan_bits;

    assign scan_bits = placed_tetrominos[int'(scan)*BLOCK_WIDTH +: BLOCK_WIDTH];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan   <= 5'd0;
            row    <= 5'd0;
            row_en <= 1'b0;
        end else begin
            row    <= scan;
            row_en <= !pause && (&scan_bits);
            if (!pause) begin
                scan <= (scan == 5'(BLOCK_HEIGHT - 1)) ? 5'd0 : scan + 5'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Debouncers: input sampling, then per-bit stability counter.
    // -----------------------------------------------------------------------
    logic [NUM_INPUTS-1:0] s;

`ifdef DEBOUNCE_SYNC_EN
    logic [NUM_INPUTS-1:0] sync_1;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= '0;
            s      <= '0;
        end else begin
            sync_1 <= raw;
            s      <= sync_1;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            s <= '0;
        end else begin
            s <= raw;
        end
    end
`endif

    logic [NUM_INPUTS-1:0] state;
    logic [CNT_W-1:0]      cnt [NUM_INPUTS];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= '0;
            db_enabled  <= '0;
            db_disabled <= '0;
            // NOTE: the counter array is control state, not storage, so it
            // is reset explicitly rather than left to power-up values.
            for (int i = 0; i < NUM_INPUTS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                db_enabled[i]  <= 1'b0;
                db_disabled[i] <= 1'b0;
                if (s[i] == state[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    // Level has been stable long enough: accept it.
                    state[i]       <= s[i];
                    cnt[i]         <= '0;
                    db_enabled[i]  <= s[i];
                    db_disabled[i] <= !s[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tetris_piece_row_logic.sv
// ---------------------------------------------------------------------------
// tb_tetris_piece_row_logic
//
// Directed bench for tetris_piece_row_logic with DEBOUNCE_CYCLES = 4.
// Outputs are sampled on the falling clock edge; inputs change there too.
// ---------------------------------------------------------------------------
module tb_tetris_piece_row_logic;

    localparam int BW = 10;
    localparam int BH = 20;
    localparam int NI = 7;
    localparam int DC = 4;
`ifdef DEBOUNCE_SYNC_EN
    localparam int L = DC + 2;
`else
    localparam int L = DC + 1;
`endif

    logic              clk;
    logic              rst;
    logic [1:0]        piece;
    logic [3:0]        pos_x;
    logic [4:0]        pos_y;
    logic [1:0]        rot;
    logic [7:0]        blk_1, blk_2, blk_3, blk_4;
    logic [2:0]        width, height;
    logic              pause;
    logic [BW*BH-1:0]  placed_tetrominos;
    logic [4:0]        row;
    logic              row_en;
    logic [NI-1:0]     raw;
    logic [NI-1:0]     db_enabled;
    logic [NI-1:0]     db_disabled;

    int tests  = 0;
    int failed = 0;
    int exp_scan;

    tetris_piece_row_logic #(
        .BLOCK_WIDTH    (BW),
        .BLOCK_HEIGHT   (BH),
        .NUM_INPUTS     (NI),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .piece            (piece),
        .pos_x            (pos_x),
        .pos_y            (pos_y),
        .rot              (rot),
        .blk_1            (blk_1),
        .blk_2            (blk_2),
        .blk_3            (blk_3),
        .blk_4            (blk_4),
        .width            (width),
        .height           (height),
        .pause            (pause),
        .placed_tetrominos(placed_tetrominos),
        .row              (row),
        .row_en           (row_en),
        .raw              (raw),
        .db_enabled       (db_enabled),
        .db_disabled      (db_disabled)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic geom(input logic [1:0] p, input logic [3:0] x, input logic [4:0] y,
                        input logic [1:0] r, input int b1, input int b2, input int b3,
                        input int b4, input int w, input int h);
        piece = p; pos_x = x; pos_y = y; rot = r;
        #1;
        check("blk_1", 32'(blk_1), b1);
        check("blk_2", 32'(blk_2), b2);
        check("blk_3", 32'(blk_3), b3);
        check("blk_4", 32'(blk_4), b4);
        check("width", 32'(width), w);
        check("height", 32'(height), h);
    endtask

    // One edge of the row scanner; row 19 is the only full row on the board.
    task automatic scan_step();
        int  e_row;
        logic e_en;
        @(posedge clk);
        e_row = exp_scan;
        e_en  = !pause && (exp_scan == 19);
        if (!pause) exp_scan = (exp_scan == BH - 1) ? 0 : exp_scan + 1;
        @(negedge clk);
        check("row", 32'(row), e_row);
        check("row_en", 32'(row_en), 32'(e_en));
    endtask

    // Runs n edges; both pulse vectors must be zero except on edge pulse_at.
    task automatic db_run(input int n, input int pulse_at,
                          input logic [NI-1:0] en_exp, input logic [NI-1:0] dis_exp);
        for (int e = 1; e <= n; e++) begin
            tick();
            check("db_enabled", 32'(db_enabled), (e == pulse_at) ? 32'(en_exp) : 32'd0);
            check("db_disabled", 32'(db_disabled), (e == pulse_at) ? 32'(dis_exp) : 32'd0);
        end
    endtask

    initial begin
        rst   = 1'b1;
        pause = 1'b0;
        raw   = '0;
        piece = 2'd0; pos_x = 4'd0; pos_y = 5'd0; rot = 2'd0;
        placed_tetrominos = '0;
        placed_tetrominos[19*BW +: BW] = '1;        // row 19 full
        placed_tetrominos[18*BW +: BW] = 10'h1FF;   // row 18 one short

        // Reset state
        repeat (3) tick();
        check("rst_row", 32'(row), 0);
        check("rst_row_en", 32'(row_en), 0);
        check("rst_db_enabled", 32'(db_enabled), 0);
        check("rst_db_disabled", 32'(db_disabled), 0);

        // Geometry
        geom(2'd3, 4'd4, 5'd0, 2'd1, 5, 14, 15, 25, 2, 3);
        geom(2'd1, 4'd6, 5'd19, 2'd0, 196, 197, 198, 199, 4, 1);
        geom(2'd1, 4'd0, 5'd0, 2'd3, 0, 10, 20, 30, 1, 4);
        geom(2'd3, 4'd0, 5'd0, 2'd0, 0, 1, 2, 11, 3, 2);
        geom(2'd3, 4'd2, 5'd3, 2'd2, 33, 42, 43, 44, 3, 2);
        geom(2'd3, 4'd1, 5'd1, 2'd3, 11, 21, 22, 31, 2, 3);
        geom(2'd0, 4'd5, 5'd7, 2'd2, 0, 0, 0, 0, 0, 0);
        for (int r = 0; r < 4; r++) begin
            geom(2'd2, 4'd0, 5'd0, 2'(r), 0, 1, 10, 11, 2, 2);
        end

        // Row scanner: free run, pause when scan reaches 19, then resume
        rst = 1'b0;
        exp_scan = 0;
        repeat (79) scan_step();
        pause = 1'b1;
        repeat (50) scan_step();
        pause = 1'b0;
        repeat (30) scan_step();

        // Debouncer: press, 3-cycle glitch, release
        raw[2] = 1'b1;
        db_run(L + 2, L, 7'b0000100, 7'b0000000);
        raw[2] = 1'b0;
        db_run(3, 0, '0, '0);
        raw[2] = 1'b1;
        db_run(10, 0, '0, '0);
        raw[2] = 1'b0;
        db_run(L + 2, L, 7'b0000000, 7'b0000100);

        // Reset during a count with a full row present; raw stays high
        raw[2] = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        for (int e = 0; e < 2; e++) begin
            tick();
            check("rst2_row", 32'(row), 0);
            check("rst2_row_en", 32'(row_en), 0);
            check("rst2_db_enabled", 32'(db_enabled), 0);
            check("rst2_db_disabled", 32'(db_disabled), 0);
        end
        rst = 1'b0;
        tick();
        check("post_rst_row", 32'(row), 0);
        check("post_rst_db_enabled", 32'(db_enabled), 0);
        db_run(L, L - 1, 7'b0000100, 7'b0000000);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
